prom_programmer: RTL

//  Initiator side of the PROM program/read port: accepts a byte stream from a host and burns it into

---
 rtl/prom_prog_pkg.sv | 18 +
 rtl/prom_programmer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/prom_prog_pkg.sv
// rtl/prom_prog_pkg.sv - state encoding and counter sizing helper for prom_programmer
package prom_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PROG,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Width of a counter that must hold 0..max_retry; never narrower than one bit.
    function automatic int retry_cnt_w(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/prom_programmer.sv
// rtl/prom_programmer.sv - burns a host byte stream into consecutive PROM addresses
// PROM_PROG_VERIFY_EN adds a read-back verify with bounded re-program retries.
module prom_programmer
    import prom_prog_pkg::*;
#(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_bytes,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic              prom_cs,
    output logic              prom_program,
    output logic              prom_read,
    output logic [ADDR_W-1:0] prom_addr,
    output logic [DATA_W-1:0] prom_wdata,
    input  logic [DATA_W-1:0] prom_rdata
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   byte_q, byte_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic                cs_q, prog_q, read_q;
    logic                adv;

`ifdef PROM_PROG_VERIFY_EN
    localparam int RW = retry_cnt_w(MAX_RETRY);
    logic [RW-1:0]       retry_q, retry_d;
`else
    logic                unused_rdata;
    assign unused_rdata = ^prom_rdata;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        adv        = 1'b0;
`ifdef PROM_PROG_VERIFY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = start_addr;
                    cnt_d      = num_bytes;
                    error_d    = 1'b0;
                    err_addr_d = '0;
`ifdef PROM_PROG_VERIFY_EN
                    retry_d    = '0;
`endif
                    state_d    = (num_bytes == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (in_valid) begin
                    byte_d  = in_data;
                    state_d = ST_PROG;
                end
            end
`ifdef PROM_PROG_VERIFY_EN
            ST_PROG:  state_d = ST_READ;
            ST_READ:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (prom_rdata == byte_q) begin
                    adv = 1'b1;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_PROG;
                end else begin
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = ST_DONE;
                end
            end
`else
            ST_PROG:  adv = 1'b1;
`endif
            default:  state_d = ST_IDLE;
        endcase

        // Byte committed: step to the next address (wrapping) or finish the job.
        if (adv) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == (ADDR_W+1)'(1)) begin
                state_d = ST_DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = ST_FETCH;
            end
`ifdef PROM_PROG_VERIFY_EN
            retry_d = '0;
`endif
        end
    end

    // Strobes are registered from the next state so they are clean for the whole state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            byte_q     <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            cs_q       <= 1'b0;
            prog_q     <= 1'b0;
            read_q     <= 1'b0;
`ifdef PROM_PROG_VERIFY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
            cs_q       <= (state_d == ST_PROG) || (state_d == ST_READ);
            prog_q     <= (state_d == ST_PROG);
            read_q     <= (state_d == ST_READ);
`ifdef PROM_PROG_VERIFY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign in_ready     = (state_q == ST_FETCH);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign error        = error_q;
    assign err_addr     = err_addr_q;
    assign prom_cs      = cs_q;
    assign prom_program = prog_q;
    assign prom_read    = read_q;
    assign prom_addr    = addr_q;
    assign prom_wdata   = byte_q;

endmodule
